// File: rtl/jtag_dtm_sync_if.sv
// jtag_dtm_sync_if: DMI request/response channel between the DTM and the debug module
interface jtag_dtm_sync_if #(parameter int ABITS = 7);
  logic             dmi_req_valid_o;
  logic             dmi_req_ready_i;
  logic [ABITS-1:0] dmi_req_addr_o;
  logic [31:0]      dmi_req_data_o;
  logic [1:0]       dmi_req_op_o;
  logic             dmi_rsp_valid_i;
  logic             dmi_rsp_ready_o;
  logic [31:0]      dmi_rsp_data_i;
  logic [1:0]       dmi_rsp_resp_i;
  modport master (
    output dmi_req_valid_o, dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o, dmi_rsp_ready_o,
    input  dmi_req_ready_i, dmi_rsp_valid_i, dmi_rsp_data_i, dmi_rsp_resp_i
  );
  modport slave (
    input  dmi_req_valid_o, dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o, dmi_rsp_ready_o,
    output dmi_req_ready_i, dmi_rsp_valid_i, dmi_rsp_data_i, dmi_rsp_resp_i
  );
endinterface

// File: rtl/jtag_dtm_sync.sv
// jtag_dtm_sync: JTAG debug transport module with oversampled TAP and a DMI request port
module jtag_dtm_sync #(
  parameter logic [31:0] IDCODE = 32'h1000_0001,
  parameter int          ABITS  = 7
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tck_i,
  input  logic tms_i,
  input  logic tdi_i,
  output logic tdo_o,
  jtag_dtm_sync_if.master dmi
);
  localparam int DW = ABITS + 34;
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
  } tap_t;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} req_t;
  logic [2:0] tck_sy;
  logic [1:0] tms_sy, tdi_sy;
  logic tck_rise, tck_fall, tms, tdi;
  tap_t tap, tap_nx;
  req_t rq, rq_nx;
  logic [4:0] ir, ir_sh;
  logic [DW-1:0] dr_sh, dr_cap, dr_shift;
  logic [1:0] dmistat, op_q;
  logic [ABITS-1:0] addr_q;
  logic [31:0] wdata_q, rdata_q;
  logic is_idcode, is_dtmcs, is_dmi, upd_dtmcs, upd_dmi, hard_reset, issue, rsp_take;
  // tck_sy[2] is the previous synchronized tck, used for edge detection
  assign tck_rise = tck_sy[1] & ~tck_sy[2];
  assign tck_fall = ~tck_sy[1] & tck_sy[2];
  assign tms = tms_sy[1];
  assign tdi = tdi_sy[1];
  assign is_idcode = ir == 5'h01;
  assign is_dtmcs = ir == 5'h10;
  assign is_dmi = ir == 5'h11;
  assign upd_dtmcs = tck_fall && tap == UPD_DR && is_dtmcs;
  assign upd_dmi = tck_fall && tap == UPD_DR && is_dmi;
  assign hard_reset = upd_dtmcs & dr_sh[17];
  assign issue = upd_dmi && rq == IDLE && dmistat == 2'd0 && (dr_sh[1] ^ dr_sh[0]);
  assign rsp_take = rq == WAIT_RSP && dmi.dmi_rsp_valid_i && !hard_reset;
  assign dr_cap = is_dmi ? {addr_q, rdata_q, dmistat} :
                  is_idcode ? DW'(IDCODE) :
                  is_dtmcs ? DW'({17'd0, 3'd1, dmistat, 6'(ABITS), 4'd1}) : '0;
  assign dmi.dmi_req_addr_o = addr_q;
  assign dmi.dmi_req_data_o = wdata_q;
  assign dmi.dmi_req_op_o = op_q;
  // TDI enters at the top of whichever DR length the current instruction selects
  always_comb begin
    dr_shift = dr_sh >> 1;
    if (is_dmi) dr_shift[DW-1] = tdi;
    else if (is_idcode || is_dtmcs) dr_shift[31] = tdi;
    else dr_shift[0] = tdi;
  end
  always_comb begin
    tap_nx = tap;
    case (tap)
      TLR:      tap_nx = tms ? TLR : RTI;
      RTI:      tap_nx = tms ? SEL_DR : RTI;
      SEL_DR:   tap_nx = tms ? SEL_IR : CAP_DR;
      CAP_DR:   tap_nx = tms ? EX1_DR : SHIFT_DR;
      SHIFT_DR: tap_nx = tms ? EX1_DR : SHIFT_DR;
      EX1_DR:   tap_nx = tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR: tap_nx = tms ? EX2_DR : PAUSE_DR;
      EX2_DR:   tap_nx = tms ? UPD_DR : SHIFT_DR;
      UPD_DR:   tap_nx = tms ? SEL_DR : RTI;
      SEL_IR:   tap_nx = tms ? TLR : CAP_IR;
      CAP_IR:   tap_nx = tms ? EX1_IR : SHIFT_IR;
      SHIFT_IR: tap_nx = tms ? EX1_IR : SHIFT_IR;
      EX1_IR:   tap_nx = tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR: tap_nx = tms ? EX2_IR : PAUSE_IR;
      EX2_IR:   tap_nx = tms ? UPD_IR : SHIFT_IR;
      UPD_IR:   tap_nx = tms ? SEL_DR : RTI;
      default:  tap_nx = TLR;
    endcase
  end
  // A request accepted together with a response only moves to WAIT_RSP; the response is taken later
  always_comb begin
    rq_nx = rq;
    if (hard_reset) rq_nx = IDLE;
    else if (rq == IDLE) rq_nx = issue ? REQ : IDLE;
    else if (rq == REQ) rq_nx = dmi.dmi_req_ready_i ? WAIT_RSP : REQ;
    else rq_nx = dmi.dmi_rsp_valid_i ? IDLE : WAIT_RSP;
    dmi.dmi_req_valid_o = rq == REQ;
    dmi.dmi_rsp_ready_o = rq == WAIT_RSP;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tck_sy <= '0;
      tms_sy <= '0;
      tdi_sy <= '0;
    end else begin
      tck_sy <= {tck_sy[1:0], tck_i};
      tms_sy <= {tms_sy[0], tms_i};
      tdi_sy <= {tdi_sy[0], tdi_i};
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tap <= TLR;
      rq <= IDLE;
      ir <= 5'h01;
      ir_sh <= '0;
      dr_sh <= '0;
      dmistat <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      op_q <= '0;
      tdo_o <= 1'b0;
    end else begin
      rq <= rq_nx;
      if (tck_rise) begin
        tap <= tap_nx;
        if (tap == CAP_IR) ir_sh <= 5'b00001;
        if (tap == SHIFT_IR) ir_sh <= {tdi, ir_sh[4:1]};
        if (tap == CAP_DR) dr_sh <= dr_cap;
        if (tap == SHIFT_DR) dr_sh <= dr_shift;
      end
      if (tck_fall) tdo_o <= tap == SHIFT_IR ? ir_sh[0] : tap == SHIFT_DR ? dr_sh[0] : 1'b0;
      if (tap == TLR) ir <= 5'h01;
      else if (tck_fall && tap == UPD_IR) ir <= ir_sh;
      if (issue) begin
        addr_q <= dr_sh[DW-1:34];
        wdata_q <= dr_sh[33:2];
        op_q <= dr_sh[1:0];
      end
      if (rsp_take) rdata_q <= dmi.dmi_rsp_data_i;
      if (upd_dtmcs && (dr_sh[16] || dr_sh[17])) dmistat <= 2'd0;
      else if (upd_dmi && rq != IDLE) dmistat <= 2'd3;
      else if (rsp_take && dmi.dmi_rsp_resp_i != 2'd0 && dmistat == 2'd0) dmistat <= 2'd2;
    end
  end
endmodule

// File: tb/tb_jtag_dtm_sync.sv
// tb_jtag_dtm_sync: directed JTAG/DMI scenarios with hand-computed expectations
module tb_jtag_dtm_sync;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic tck = 1'b0;
  logic tms = 1'b0;
  logic tdi = 1'b0;
  logic tdo;
  int n_chk = 0;
  int n_fail = 0;
  jtag_dtm_sync_if #(.ABITS(7)) dmi ();
  jtag_dtm_sync #(.IDCODE(32'h1000_0001), .ABITS(7)) dut (
    .clk(clk), .reset_n(reset_n), .tck_i(tck), .tms_i(tms), .tdi_i(tdi), .tdo_o(tdo), .dmi(dmi.master)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // One TCK period of 8 clk; tdo is sampled mid low phase, before the rising edge
  task automatic tck_bit(input logic m, input logic d, output logic o);
    tms = m;
    tdi = d;
    #40;
    o = tdo;
    tck = 1'b1;
    #40;
    tck = 1'b0;
  endtask
  task automatic tap_reset();
    logic o;
    repeat (5) tck_bit(1'b1, 1'b0, o);
    tck_bit(1'b0, 1'b0, o);
  endtask
  task automatic shift_ir(input logic [4:0] v, output logic [4:0] out);
    logic o;
    tck_bit(1'b1, 1'b0, o);
    tck_bit(1'b1, 1'b0, o);
    tck_bit(1'b0, 1'b0, o);
    tck_bit(1'b0, 1'b0, o);
    for (int i = 0; i < 5; i++) begin
      tck_bit(i == 4, v[i], o);
      out[i] = o;
    end
    tck_bit(1'b1, 1'b0, o);
    tck_bit(1'b0, 1'b0, o);
  endtask
  task automatic shift_dr(input logic [63:0] v, input int len, output logic [63:0] out);
    logic o;
    out = '0;
    tck_bit(1'b1, 1'b0, o);
    tck_bit(1'b0, 1'b0, o);
    tck_bit(1'b0, 1'b0, o);
    for (int i = 0; i < len; i++) begin
      tck_bit(i == len - 1, v[i], o);
      out[i] = o;
    end
    tck_bit(1'b1, 1'b0, o);
    tck_bit(1'b0, 1'b0, o);
  endtask
  function automatic logic [63:0] dmi_dr(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
    return {23'd0, a, d, op};
  endfunction
  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end
  initial begin
    logic [63:0] out;
    logic [4:0] ir_out;
    logic o;
    dmi.dmi_req_ready_i = 1'b0;
    dmi.dmi_rsp_valid_i = 1'b0;
    dmi.dmi_rsp_data_i = '0;
    dmi.dmi_rsp_resp_i = '0;
    #10;
    reset_n = 1'b0;
    #20;
    check("rst_tdo", 64'(tdo), 64'(0));
    check("rst_req_valid", 64'(dmi.dmi_req_valid_o), 64'(0));
    check("rst_rsp_ready", 64'(dmi.dmi_rsp_ready_o), 64'(0));
    check("rst_fields", 64'({dmi.dmi_req_addr_o, dmi.dmi_req_data_o, dmi.dmi_req_op_o}), 64'(0));
    reset_n = 1'b1;
    #20;
    tap_reset();
    shift_dr(64'(0), 32, out);
    check("idcode", out, 64'h1000_0001);
    shift_ir(5'h1F, ir_out);
    check("ir_capture", 64'(ir_out), 64'(5'b00001));
    shift_dr(64'hB3, 8, out);
    check("bypass", out, 64'h66);
    shift_ir(5'h11, ir_out);
    shift_dr(dmi_dr(7'h10, 32'h1, 2'd2), 41, out);
    check("wr_req", 64'({dmi.dmi_req_valid_o, dmi.dmi_req_addr_o, dmi.dmi_req_data_o, dmi.dmi_req_op_o}),
          64'({1'b1, 7'h10, 32'h1, 2'd2}));
    #30;
    check("wr_hold", 64'({dmi.dmi_req_valid_o, dmi.dmi_req_addr_o, dmi.dmi_req_data_o, dmi.dmi_req_op_o}),
          64'({1'b1, 7'h10, 32'h1, 2'd2}));
    dmi.dmi_req_ready_i = 1'b1;
    #10;
    dmi.dmi_req_ready_i = 1'b0;
    check("wr_accept", 64'({dmi.dmi_req_valid_o, dmi.dmi_rsp_ready_o}), 64'(2'b01));
    dmi.dmi_rsp_valid_i = 1'b1;
    dmi.dmi_rsp_data_i = 32'hCAFE_0001;
    #10;
    dmi.dmi_rsp_valid_i = 1'b0;
    check("wr_rsp_done", 64'(dmi.dmi_rsp_ready_o), 64'(0));
    shift_dr(dmi_dr(7'h00, 32'h0, 2'd0), 41, out);
    check("wr_capture", out, dmi_dr(7'h10, 32'hCAFE_0001, 2'd0));
    check("nop_no_req", 64'(dmi.dmi_req_valid_o), 64'(0));
    shift_dr(dmi_dr(7'h05, 32'h0, 2'd1), 41, out);
    check("rd_req", 64'({dmi.dmi_req_valid_o, dmi.dmi_req_addr_o, dmi.dmi_req_op_o}), 64'({1'b1, 7'h05, 2'd1}));
    shift_dr(dmi_dr(7'h06, 32'h0, 2'd1), 41, out);
    check("busy_keeps_req", 64'({dmi.dmi_req_valid_o, dmi.dmi_req_addr_o}), 64'({1'b1, 7'h05}));
    shift_dr(dmi_dr(7'h00, 32'h0, 2'd0), 41, out);
    check("busy_capture_op", 64'(out[1:0]), 64'(2'd3));
    dmi.dmi_req_ready_i = 1'b1;
    dmi.dmi_rsp_valid_i = 1'b1;
    dmi.dmi_rsp_data_i = 32'hBAD0_BAD0;
    #10;
    dmi.dmi_req_ready_i = 1'b0;
    dmi.dmi_rsp_data_i = 32'h1234_5678;
    check("same_cycle_rsp_deferred", 64'({dmi.dmi_req_valid_o, dmi.dmi_rsp_ready_o}), 64'(2'b01));
    #10;
    dmi.dmi_rsp_valid_i = 1'b0;
    check("rd_rsp_done", 64'(dmi.dmi_rsp_ready_o), 64'(0));
    shift_ir(5'h10, ir_out);
    shift_dr(64'h0001_0000, 32, out);
    check("dtmcs_busy", out, 64'h1C71);
    shift_dr(64'(0), 32, out);
    check("dtmcs_dmireset", out, 64'h1071);
    shift_ir(5'h11, ir_out);
    shift_dr(dmi_dr(7'h07, 32'h0, 2'd1), 41, out);
    check("rd_capture", out, dmi_dr(7'h05, 32'h1234_5678, 2'd0));
    dmi.dmi_req_ready_i = 1'b1;
    #10;
    dmi.dmi_req_ready_i = 1'b0;
    dmi.dmi_rsp_valid_i = 1'b1;
    dmi.dmi_rsp_resp_i = 2'd2;
    dmi.dmi_rsp_data_i = 32'h0;
    #10;
    dmi.dmi_rsp_valid_i = 1'b0;
    dmi.dmi_rsp_resp_i = 2'd0;
    shift_ir(5'h10, ir_out);
    shift_dr(64'(0), 32, out);
    check("dtmcs_error", out, 64'h1871);
    shift_ir(5'h11, ir_out);
    shift_dr(dmi_dr(7'h08, 32'h0, 2'd1), 41, out);
    check("error_blocks_req", 64'(dmi.dmi_req_valid_o), 64'(0));
    shift_ir(5'h10, ir_out);
    shift_dr(64'h0001_0000, 32, out);
    shift_ir(5'h11, ir_out);
    shift_dr(dmi_dr(7'h09, 32'h0, 2'd1), 41, out);
    check("req_after_dmireset", 64'({dmi.dmi_req_valid_o, dmi.dmi_req_addr_o}), 64'({1'b1, 7'h09}));
    tap_reset();
    check("tlr_keeps_req", 64'(dmi.dmi_req_valid_o), 64'(1));
    shift_ir(5'h10, ir_out);
    shift_dr(64'h0002_0000, 32, out);
    check("hardreset_drop", 64'({dmi.dmi_req_valid_o, dmi.dmi_rsp_ready_o}), 64'(0));
    shift_ir(5'h11, ir_out);
    shift_dr(dmi_dr(7'h0A, 32'h55, 2'd2), 41, out);
    check("pre_reset_req", 64'(dmi.dmi_req_valid_o), 64'(1));
    reset_n = 1'b0;
    #1;
    check("async_drop", 64'({dmi.dmi_req_valid_o, dmi.dmi_rsp_ready_o, dmi.dmi_req_addr_o}), 64'(0));
    #19;
    reset_n = 1'b1;
    dmi.dmi_rsp_valid_i = 1'b1;
    #20;
    check("rsp_ignored", 64'({dmi.dmi_req_valid_o, dmi.dmi_rsp_ready_o}), 64'(0));
    dmi.dmi_rsp_valid_i = 1'b0;
    tck_bit(1'b0, 1'b0, o);
    shift_dr(64'(0), 32, out);
    check("idcode_after_reset", out, 64'h1000_0001);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
